// File: rtl/mx_int_dot_acc.sv
// rtl/mx_int_dot_acc.sv - signed integer dot-product accumulator for MX blocks
//
// Purpose: multiplies one pair of signed elements per accepted handshake and
// sums block_size products in a full-precision accumulator. Each completed
// block yields one saturated two's-complement sum held in a one-deep output
// register until downstream consumes it.
//
// Ports:
//   i_clk    - clock, rising edge
//   i_rst_n  - asynchronous active-low reset
//   i_valid  - input pair valid
//   o_ready  - a pair can be accepted this cycle
//   i_a/i_b  - signed input elements (in_width)
//   i_flush  - discard the partial block (and any pair accepted this cycle)
//   o_valid  - o_sum holds a completed block result
//   i_ready  - downstream consumes o_sum
//   o_sum    - saturated block sum (out_width)
//   o_sat    - o_sum was clamped
module mx_int_dot_acc #(
  parameter int in_width   = 8,
  parameter int block_size = 32,
  parameter int out_width  = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [in_width-1:0]  i_a,
  input  logic [in_width-1:0]  i_b,
  input  logic                 i_flush,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [out_width-1:0] o_sum,
  output logic                 o_sat
);

  localparam int acc_width = 2 * in_width + $clog2(block_size);
  localparam int cnt_width = $clog2(block_size);
  // Comparison width covers both the accumulator and the output range, plus
  // one bit so the clamp limits are representable whatever the parameters.
  localparam int cmp_width = ((acc_width > out_width) ? acc_width : out_width) + 1;

  localparam logic [cnt_width-1:0] c_last = cnt_width'(block_size - 1);
  localparam logic signed [cmp_width-1:0] c_max =
    {{(cmp_width - out_width + 1){1'b0}}, {(out_width - 1){1'b1}}};
  localparam logic signed [cmp_width-1:0] c_min =
    {{(cmp_width - out_width + 1){1'b1}}, {(out_width - 1){1'b0}}};

  logic signed [acc_width-1:0]  r_acc;
  logic        [cnt_width-1:0]  r_cnt;
  logic                         r_valid;
  logic        [out_width-1:0]  r_sum;
  logic                         r_sat;

  logic signed [2*in_width-1:0] w_prod;
  logic signed [acc_width-1:0]  w_prod_ext;
  logic signed [acc_width-1:0]  w_full;
  logic signed [cmp_width-1:0]  w_full_ext;
  logic                         w_last;
  logic                         w_accept;
  logic                         w_final;
  logic                         w_consume;
  logic        [out_width-1:0]  w_sat_sum;
  logic                         w_sat_flag;

  assign w_prod     = $signed(i_a) * $signed(i_b);
  assign w_prod_ext = {{(acc_width - 2 * in_width){w_prod[2*in_width-1]}}, w_prod};
  assign w_full     = r_acc + w_prod_ext;
  assign w_full_ext = {{(cmp_width - acc_width){w_full[acc_width-1]}}, w_full};

  assign w_last    = (r_cnt == c_last);
  // The final element only stalls when the held result would be overwritten
  // before it is consumed; earlier elements always flow.
  assign o_ready   = !w_last || !r_valid || i_ready;
  assign w_accept  = i_valid && o_ready;
  // A pair accepted alongside a flush is discarded, so it never completes a block.
  assign w_final   = w_accept && w_last && !i_flush;
  assign w_consume = r_valid && i_ready;

  always_comb begin
    w_sat_sum  = w_full_ext[out_width-1:0];
    w_sat_flag = 1'b0;
    if (w_full_ext > c_max) begin
      w_sat_sum  = c_max[out_width-1:0];
      w_sat_flag = 1'b1;
    end else if (w_full_ext < c_min) begin
      w_sat_sum  = c_min[out_width-1:0];
      w_sat_flag = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else if (i_flush) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else if (w_accept) begin
      if (w_last) begin
        r_acc <= '0;
        r_cnt <= '0;
      end else begin
        r_acc <= w_full;
        r_cnt <= r_cnt + cnt_width'(1);
      end
    end
  end

  // Sum/sat only load on a final accept, so they hold while o_valid waits.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid <= 1'b0;
      r_sum   <= '0;
      r_sat   <= 1'b0;
    end else if (w_final) begin
      r_valid <= 1'b1;
      r_sum   <= w_sat_sum;
      r_sat   <= w_sat_flag;
    end else if (w_consume) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_sum   = r_sum;
  assign o_sat   = r_sat;

endmodule
